median_src: RTL and testbench
=============================

Name: median_src

Overview:
- Initiator-side streamer for the median filter, driving the filter's DI/DSI input protocol and consuming its DO/DSO result.
- Collects one window of LENGTH samples from a host write port into a local buffer.
- Streams the window to the filter with DSI held high for exactly LENGTH cycles, then waits for DSO and captures the median.
- Presents the median to the host through a valid/ready handshake. Sits between the test/host logic and the median filter.

Parameters:
- SIZE, 8, sample width in bits
- LENGTH, 9, samples per window
- TIMEOUT, 64, max cycles to wait for DSO (used only with MEDSRC_TIMEOUT_EN)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- WR_EN  in  1  host write strobe
- WR_DATA  in  SIZE  host sample
- WR_RDY  out  1  buffer accepts a write this cycle
- PIX  out  SIZE  sample to filter DI
- DSI  out  1  window-valid strobe to filter
- MED_DO  in  SIZE  filter result (filter DO)
- MED_DSO  in  1  filter result strobe (filter DSO)
- RES  out  SIZE  captured median
- RES_VALID  out  1  RES holds a valid result
- RES_READY  in  1  host consumes RES
- ERR  out  1  sticky timeout flag (tied 0 without MEDSRC_TIMEOUT_EN)

Behaviour:
- Reset (async, nRST=0): state LOAD, write index 0, send index 0. WR_RDY=1, DSI=0, PIX=0, RES=0, RES_VALID=0, ERR=0. Reset mid-window discards all buffered data. DSI drops immediately on reset assertion.
- All outputs are registered, except WR_RDY, which is decoded from state.
- LOAD:
  - WR_RDY=1.
  - WR_EN stores WR_DATA at buf[widx]; widx increments.
  - The write with widx==LENGTH-1 moves the block to SEND on the next cycle and clears widx.
  - WR_EN while WR_RDY=0 is ignored (no store, no error).
- SEND:
  - DSI=1 and PIX=buf[sidx] for sidx=0..LENGTH-1, one sample per cycle, in write order, with no gaps.
  - The first DSI=1 cycle is the cycle after the last write.
  - After the LENGTH-th sample, the next cycle has DSI=0, PIX=0, state WAIT.
  - DSI is never high for other than exactly LENGTH consecutive cycles.
- WAIT:
  - DSI=0. On the first cycle with MED_DSO=1, RES<=MED_DO, RES_VALID<=1, state HOLD.
  - MED_DSO in LOAD, SEND or HOLD is ignored.
- HOLD:
  - RES stable while RES_VALID=1.
  - RES_READY=1 → next cycle RES_VALID=0, state LOAD, WR_RDY=1.
  - RES_READY asserted early (before RES_VALID) has no effect.
- Widths: widx and sidx are $clog2(LENGTH) bits and never wrap past LENGTH-1. Buffer is LENGTH x SIZE.
- Latency: last write → first DSI = 1 cycle. MED_DSO → RES_VALID = 1 cycle.

Optional Feature:
- MEDSRC_TIMEOUT_EN defined:
  - A counter runs in WAIT.
  - If MED_DSO has not been seen after TIMEOUT cycles, set ERR=1 (sticky until reset), capture RES=0, and go to HOLD with RES_VALID=1 so the host is never deadlocked.
- MEDSRC_TIMEOUT_EN undefined: WAIT lasts indefinitely, no counter is built, ERR=0.

Decomposition:
- Package median_pkg:
  - state enum (LOAD, SEND, WAIT, HOLD)
  - default SIZE/LENGTH localparams
  - index width function ($clog2(LENGTH))
- One natural sub-module, median_src_buf: LENGTH-entry write-indexed / read-indexed register buffer. The top holds the FSM, counters and handshake.

Test Plan:
- Reset then write 9,3,7,1,5,8,2,6,4 → next cycle DSI=1 for exactly 9 cycles with PIX in that order; filter model returns DSO with DO=5 → RES=5, RES_VALID=1 one cycle later.
- Hold RES_READY=0 for 10 cycles after RES_VALID → RES stays 5, WR_RDY=0, extra WR_EN ignored; RES_READY=1 → RES_VALID=0 and WR_RDY=1 next cycle.
- Writes with random gaps in WR_EN → identical DSI burst, gapless and ordered; two back-to-back windows (0..8 then 255,...) → both medians correct, no data mixing.
- Assert nRST mid-SEND after 4 samples → DSI=0 immediately; a new full window afterwards streams only the new samples.
- Spurious MED_DSO=1 during LOAD and SEND → no RES_VALID, RES unchanged.
- With MEDSRC_TIMEOUT_EN, no MED_DSO → after 64 WAIT cycles ERR=1, RES_VALID=1, RES=0; ERR stays 1 across later windows until reset.

Source files
------------

// File: rtl/median_pkg.sv
// Shared types and constants for the median filter source streamer.
// The optional DSO timeout is enabled by defining MEDSRC_TIMEOUT_EN.
package median_pkg;

    // Control states of the streamer
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam int DEF_SIZE   = 8;
    localparam int DEF_LENGTH = 9;

    // Width of an index able to address n entries (at least one bit)
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/median_src_buf.sv
// LENGTH x SIZE window buffer: one write port addressed by the load index,
// one combinational read port addressed by the send index.
module median_src_buf
    import median_pkg::*;
#(
    parameter int SIZE   = DEF_SIZE,
    parameter int LENGTH = DEF_LENGTH,
    parameter int IW     = idx_w(LENGTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [IW-1:0]   waddr,
    input  logic [SIZE-1:0] wdata,
    input  logic [IW-1:0]   raddr,
    output logic [SIZE-1:0] rdata
);

    localparam logic [IW-1:0] LAST_IDX = IW'(LENGTH - 1);

    logic [SIZE-1:0] mem_q [LENGTH];
    logic [SIZE-1:0] mem_d [LENGTH];

    // Next buffer contents: store the sample at the write index when enabled
    always_comb begin
        mem_d = mem_q;
        if (we && (waddr <= LAST_IDX)) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Buffer registers; reset discards any partially loaded window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LENGTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = (raddr <= LAST_IDX) ? mem_q[raddr] : '0;

endmodule

// File: rtl/median_src.sv
// Initiator-side streamer for the median filter. Loads one window from the
// host, streams it on PIX/DSI for exactly LENGTH cycles, captures the filter
// result on MED_DSO and hands it to the host with a valid/ready handshake.
// Define MEDSRC_TIMEOUT_EN to add a DSO watchdog that sets the sticky ERR flag.
module median_src
    import median_pkg::*;
#(
    parameter int SIZE    = DEF_SIZE,
    parameter int LENGTH  = DEF_LENGTH,
    parameter int TIMEOUT = 64
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            WR_EN,
    input  logic [SIZE-1:0] WR_DATA,
    output logic            WR_RDY,
    output logic [SIZE-1:0] PIX,
    output logic            DSI,
    input  logic [SIZE-1:0] MED_DO,
    input  logic            MED_DSO,
    output logic [SIZE-1:0] RES,
    output logic            RES_VALID,
    input  logic            RES_READY,
    output logic            ERR
);

    localparam int            IW       = idx_w(LENGTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(LENGTH - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   widx_q, widx_d;
    logic [IW-1:0]   sidx_q, sidx_d;
    logic [SIZE-1:0] pix_q, pix_d;
    logic            dsi_q, dsi_d;
    logic [SIZE-1:0] res_q, res_d;
    logic            res_valid_q, res_valid_d;

    logic            buf_we_s;
    logic [IW-1:0]   buf_raddr_s;
    logic [SIZE-1:0] buf_rdata_s;

`ifdef MEDSRC_TIMEOUT_EN
    localparam int            TW       = idx_w(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    median_src_buf #(
        .SIZE   (SIZE),
        .LENGTH (LENGTH),
        .IW     (IW)
    ) u_buf (
        .clk   (CLK),
        .rst_n (nRST),
        .we    (buf_we_s),
        .waddr (widx_q),
        .wdata (WR_DATA),
        .raddr (buf_raddr_s),
        .rdata (buf_rdata_s)
    );

    // Next-state, index and output decode for the load/send/wait/hold sequence
    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        sidx_d      = sidx_q;
        pix_d       = pix_q;
        dsi_d       = dsi_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        buf_we_s    = 1'b0;
        buf_raddr_s = '0;
`ifdef MEDSRC_TIMEOUT_EN
        tmo_d       = '0;
        err_d       = err_q;
`endif
        case (state_q)
            ST_LOAD: begin
                dsi_d = 1'b0;
                pix_d = '0;
                if (WR_EN) begin
                    buf_we_s = 1'b1;
                    if (widx_q == LAST_IDX) begin
                        // Last sample: present the first one on the very next cycle.
                        // A one-entry window has to bypass the buffer write.
                        widx_d  = '0;
                        sidx_d  = '0;
                        state_d = ST_SEND;
                        dsi_d   = 1'b1;
                        pix_d   = (LENGTH == 1) ? WR_DATA : buf_rdata_s;
                    end else begin
                        widx_d = widx_q + IW'(1);
                    end
                end else begin
                    widx_d = widx_q;
                end
            end
            ST_SEND: begin
                // sidx_q is the sample currently on PIX
                if (sidx_q == LAST_IDX) begin
                    sidx_d  = '0;
                    dsi_d   = 1'b0;
                    pix_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    sidx_d      = sidx_q + IW'(1);
                    buf_raddr_s = sidx_q + IW'(1);
                    pix_d       = buf_rdata_s;
                    dsi_d       = 1'b1;
                end
            end
            ST_WAIT: begin
                dsi_d = 1'b0;
                pix_d = '0;
                if (MED_DSO) begin
                    res_d       = MED_DO;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
`ifdef MEDSRC_TIMEOUT_EN
                    if (tmo_q == TMO_LAST) begin
                        // Filter never answered: release the host with a zero result
                        err_d       = 1'b1;
                        res_d       = '0;
                        res_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
`else
                    res_valid_d = 1'b0;
`endif
                end
            end
            ST_HOLD: begin
                if (RES_READY) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_LOAD;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_LOAD;
                widx_d      = '0;
                sidx_d      = '0;
                pix_d       = '0;
                dsi_d       = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= ST_LOAD;
            widx_q      <= '0;
            sidx_q      <= '0;
            pix_q       <= '0;
            dsi_q       <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            sidx_q      <= sidx_d;
            pix_q       <= pix_d;
            dsi_q       <= dsi_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

`ifdef MEDSRC_TIMEOUT_EN
    // Watchdog counter and sticky error flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign WR_RDY    = (state_q == ST_LOAD);
    assign PIX       = pix_q;
    assign DSI       = dsi_q;
    assign RES       = res_q;
    assign RES_VALID = res_valid_q;

endmodule

// File: tb/tb_median_src.sv
// Directed self-checking bench for median_src (SIZE=8, LENGTH=9, TIMEOUT=64).
// Plays host and filter: writes windows, checks the DSI burst sample by
// sample, answers with DSO carrying the hand-computed median.
module tb_median_src;

    logic       CLK;
    logic       nRST;
    logic       WR_EN;
    logic [7:0] WR_DATA;
    logic       WR_RDY;
    logic [7:0] PIX;
    logic       DSI;
    logic [7:0] MED_DO;
    logic       MED_DSO;
    logic [7:0] RES;
    logic       RES_VALID;
    logic       RES_READY;
    logic       ERR;

    int         errors;
    int         checks;
    logic [7:0] exp_res;

    median_src #(.SIZE(8), .LENGTH(9), .TIMEOUT(64)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .WR_EN     (WR_EN),
        .WR_DATA   (WR_DATA),
        .WR_RDY    (WR_RDY),
        .PIX       (PIX),
        .DSI       (DSI),
        .MED_DO    (MED_DO),
        .MED_DSO   (MED_DSO),
        .RES       (RES),
        .RES_VALID (RES_VALID),
        .RES_READY (RES_READY),
        .ERR       (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    // Load a window (optional random gaps, optional spurious DSO) and check the burst
    task automatic send_window(input logic [7:0] d [9], input int maxgap, input bit spur);
        if (spur) begin
            MED_DSO = 1'b1;
            MED_DO  = 8'h77;
        end
        for (int i = 0; i < 9; i++) begin
            repeat ($urandom_range(0, maxgap)) step();
            checks++;
            if (WR_RDY !== 1'b1) begin
                errors++;
                $display("FAIL wr_rdy_load[%0d]: got %b expected 1", i, WR_RDY);
            end
            WR_EN   = 1'b1;
            WR_DATA = d[i];
            step();
            WR_EN   = 1'b0;
        end
        for (int i = 0; i < 9; i++) begin
            if (i > 0) step();
            checks++;
            if (DSI !== 1'b1 || PIX !== d[i]) begin
                errors++;
                $display("FAIL stream[%0d]: got DSI=%b PIX=%0d expected DSI=1 PIX=%0d", i, DSI, PIX, d[i]);
            end
        end
        step();
        checks++;
        if (DSI !== 1'b0 || PIX !== 8'd0) begin
            errors++;
            $display("FAIL stream_end: got DSI=%b PIX=%0d expected DSI=0 PIX=0", DSI, PIX);
        end
        if (spur) begin
            MED_DSO = 1'b0;
            MED_DO  = 8'd0;
            checks++;
            if (RES_VALID !== 1'b0 || RES !== exp_res) begin
                errors++;
                $display("FAIL spurious_dso: got RES_VALID=%b RES=%0d expected 0 and %0d", RES_VALID, RES, exp_res);
            end
        end
    endtask

    // Filter answers with the median; result must be valid one cycle later
    task automatic respond(input logic [7:0] med);
        repeat (2) step();
        checks++;
        if (RES_VALID !== 1'b0) begin
            errors++;
            $display("FAIL wait_no_valid: got RES_VALID=%b expected 0", RES_VALID);
        end
        MED_DSO = 1'b1;
        MED_DO  = med;
        step();
        MED_DSO = 1'b0;
        MED_DO  = 8'd0;
        exp_res = med;
        checks++;
        if (RES_VALID !== 1'b1 || RES !== med) begin
            errors++;
            $display("FAIL capture: got RES_VALID=%b RES=%0d expected 1 and %0d", RES_VALID, RES, med);
        end
    endtask

    task automatic release_res;
        RES_READY = 1'b1;
        step();
        RES_READY = 1'b0;
        checks++;
        if (RES_VALID !== 1'b0 || WR_RDY !== 1'b1) begin
            errors++;
            $display("FAIL release: got RES_VALID=%b WR_RDY=%b expected 0 and 1", RES_VALID, WR_RDY);
        end
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if (WR_RDY !== 1'b1 || DSI !== 1'b0 || PIX !== 8'd0 || RES !== 8'd0 || RES_VALID !== 1'b0 || ERR !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got WR_RDY=%b DSI=%b PIX=%0d RES=%0d RES_VALID=%b ERR=%b expected 1 0 0 0 0 0",
                     WR_RDY, DSI, PIX, RES, RES_VALID, ERR);
        end
        @(negedge CLK);
        nRST = 1'b1;
        step();
        checks++;
        if (WR_RDY !== 1'b1 || DSI !== 1'b0 || RES_VALID !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got WR_RDY=%b DSI=%b RES_VALID=%b expected 1 0 0", WR_RDY, DSI, RES_VALID);
        end
        exp_res = 8'd0;
    endtask

    task automatic test_basic;
        logic [7:0] w [9];
        w = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4};
        send_window(w, 0, 1'b0);
        respond(8'd5);
    endtask

    task automatic test_hold;
        for (int i = 0; i < 10; i++) begin
            WR_EN   = 1'b1;
            WR_DATA = 8'hAA;
            step();
            checks++;
            if (RES !== 8'd5 || RES_VALID !== 1'b1 || WR_RDY !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got RES=%0d RES_VALID=%b WR_RDY=%b expected 5 1 0", i, RES, RES_VALID, WR_RDY);
            end
        end
        WR_EN = 1'b0;
        release_res();
    endtask

    task automatic test_gaps;
        logic [7:0] w [9];
        w = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd8, 8'd2, 8'd6, 8'd4};
        send_window(w, 3, 1'b0);
        respond(8'd5);
        release_res();
    endtask

    task automatic test_back_to_back;
        logic [7:0] w0 [9];
        logic [7:0] w1 [9];
        w0 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        w1 = '{8'd255, 8'd254, 8'd253, 8'd252, 8'd251, 8'd250, 8'd249, 8'd248, 8'd247};
        send_window(w0, 0, 1'b0);
        RES_READY = 1'b1;            // early ready must not disturb WAIT
        respond(8'd4);
        step();
        RES_READY = 1'b0;
        checks++;
        if (RES_VALID !== 1'b0 || WR_RDY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_release: got RES_VALID=%b WR_RDY=%b expected 0 and 1", RES_VALID, WR_RDY);
        end
        send_window(w1, 0, 1'b0);
        respond(8'd251);
        release_res();
    endtask

    task automatic test_reset_mid_send;
        logic [7:0] w [9];
        logic [7:0] w2 [9];
        w  = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18};
        w2 = '{8'd28, 8'd20, 8'd27, 8'd21, 8'd24, 8'd26, 8'd22, 8'd25, 8'd23};
        for (int i = 0; i < 9; i++) begin
            WR_EN   = 1'b1;
            WR_DATA = w[i];
            step();
            WR_EN   = 1'b0;
        end
        repeat (3) step();
        checks++;
        if (DSI !== 1'b1 || PIX !== 8'd13) begin
            errors++;
            $display("FAIL mid_send: got DSI=%b PIX=%0d expected 1 and 13", DSI, PIX);
        end
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (DSI !== 1'b0 || PIX !== 8'd0 || WR_RDY !== 1'b1 || RES_VALID !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got DSI=%b PIX=%0d WR_RDY=%b RES_VALID=%b expected 0 0 1 0", DSI, PIX, WR_RDY, RES_VALID);
        end
        exp_res = 8'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        step();
        send_window(w2, 1, 1'b0);
        respond(8'd24);
        release_res();
    endtask

    task automatic test_spurious;
        logic [7:0] w [9];
        w = '{8'd50, 8'd40, 8'd60, 8'd30, 8'd70, 8'd20, 8'd80, 8'd10, 8'd90};
        send_window(w, 1, 1'b1);
        respond(8'd50);
        release_res();
    endtask

`ifdef MEDSRC_TIMEOUT_EN
    task automatic test_timeout;
        logic [7:0] w [9];
        int n;
        w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        send_window(w, 0, 1'b0);
        n = 0;
        while (RES_VALID !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n != 64 || RES !== 8'd0 || ERR !== 1'b1) begin
            errors++;
            $display("FAIL timeout: got cycles=%0d RES=%0d ERR=%b expected 64 0 1", n, RES, ERR);
        end
        exp_res = 8'd0;
        release_res();
        send_window(w, 0, 1'b0);
        respond(8'd5);
        release_res();
        checks++;
        if (ERR !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got ERR=%b expected 1", ERR);
        end
    endtask
`else
    task automatic test_no_err;
        checks++;
        if (ERR !== 1'b0) begin
            errors++;
            $display("FAIL err_tied: got ERR=%b expected 0", ERR);
        end
    endtask
`endif

    initial begin
        errors    = 0;
        checks    = 0;
        exp_res   = 8'd0;
        nRST      = 1'b0;
        WR_EN     = 1'b0;
        WR_DATA   = 8'd0;
        MED_DO    = 8'd0;
        MED_DSO   = 1'b0;
        RES_READY = 1'b0;

        test_reset();
        test_basic();
        test_hold();
        test_gaps();
        test_back_to_back();
        test_reset_mid_send();
        test_spurious();
`ifdef MEDSRC_TIMEOUT_EN
        test_timeout();
`else
        test_no_err();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
